not_16: RTL and testbench
=========================

// Module: not_16
// PURPOSE
//   16-bit bitwise inverter, the basic NOT element of the CPU gate library.
//   out is the combinational complement of in, with zero latency.
//   out_q is a registered copy of the complement for pipelined datapaths.
//   Used by the ALU and other logic blocks that need a negated operand.
// PARAMETERS
//   WIDTH     16   data width in bits; the CPU uses only 16
//   RST_VAL   0    value loaded into out_q on reset (WIDTH bits)
// PORTS
//   clk        in   1      system clock; rising edge active
//   rst        in   1      asynchronous reset, active-high
//   in         in   WIDTH  operand to invert
//   en         in   1      capture enable for the output register
//   out        out  WIDTH  combinational result, ~in
//   out_q      out  WIDTH  registered result
//   out_valid  out  1      high when out_q holds a captured result
// BEHAVIOUR
//   - out = ~in, bit for bit (out[i] = !in[i] for every i).
//     - Purely combinational: no clock, reset or enable dependence.
//     - Follows in within the same delta cycle.
//   - Reset is asynchronous and active-high.
//     - While rst=1: out_q = RST_VAL and out_valid = 0, regardless of clk or en.
//     - rst does not affect out.
//   - Rising edge of clk with rst=0 and en=1:
//     - out_q <= ~in; out_valid <= 1.
//     - Latency is one cycle from in to out_q.
//   - Rising edge of clk with rst=0 and en=0:
//     - out_q and out_valid hold their values.
//   - Reset asserted mid-operation clears out_q and out_valid immediately.
//     - The first capture after reset deasserts is the first edge with en=1.
//   - No X propagation from the register: after reset, out_q is always defined.
//   - All-ones input gives 0x0000; all-zeros input gives 0xFFFF (no special case).
// TESTING
//   - in=16'b0001_1001_0111_0101 (0x1975) -> out=0xE68A immediately.
//   - in=16'b1111_1001_0111_0101 (0xF975) -> out=0x068A; in=0xFFFF -> out=0x0000.
//   - in=0x0000 -> out=0xFFFF. Walk a single 1 through bits 0..15: out has only that bit 0.
//   - rst=1, toggle clk with en=1 -> out_q=0x0000, out_valid=0. Release rst,
//     in=0x1975, en=1, one edge -> out_q=0xE68A, out_valid=1.
//   - en=0, change in to 0xAAAA, clock 3 edges -> out_q stays 0xE68A, out=0x5555.
//   - Assert rst between edges with out_q=0xE68A -> out_q=0x0000 and out_valid=0
//     at once, with no clock edge needed.

Source files
------------

// File: rtl/not_16.sv
// -----------------------------------------------------------------------------
// not_16 -- bitwise inverter, the NOT element of the CPU gate library.
//
// Provides the complement of an operand on two paths:
//   * out   : combinational ~in, zero latency, independent of clk/rst/en.
//   * out_q : registered ~in, captured on a rising clk edge while en=1,
//             for datapaths that want the negated operand pipelined.
//
// Parameters
//   WIDTH    data width in bits (the CPU uses 16)
//   RST_VAL  value out_q takes while rst is asserted
//
// Ports
//   clk        in   1      system clock, rising edge active
//   rst        in   1      asynchronous reset, active-high
//   in         in   WIDTH  operand to invert
//   en         in   1      capture enable for the output register
//   out        out  WIDTH  combinational result, ~in
//   out_q      out  WIDTH  registered result
//   out_valid  out  1      high when out_q holds a captured result
//
// Valid semantics: out_valid is a level, not a handshake. It drops while rst
// is high and rises on the first enabled edge after reset; from then on out_q
// always holds the complement of the operand seen at the most recent edge
// with en=1. There is no ready input: the register never stalls, en alone
// decides whether an edge captures.
// -----------------------------------------------------------------------------
module not_16 #(
    parameter int unsigned       WIDTH   = 16,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);

    // Combinational path. Reset and enable deliberately play no part here so
    // the ALU sees the negated operand in the same cycle it is presented.
    logic [WIDTH-1:0] inv;

    assign inv = ~in;
    assign out = inv;

    // Registered path. Reset is asynchronous so out_q/out_valid clear the
    // moment rst rises, without waiting for a clock edge. The register is
    // loaded from the same inverted value as the combinational output, so
    // both paths always agree on the function.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= RST_VAL;
            out_valid <= 1'b0;
        end else if (en) begin
            out_q     <= inv;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_not_16.sv
// -----------------------------------------------------------------------------
// tb_not_16 -- directed self-checking bench for not_16.
// Expected values are hand-computed constants; the registered path uses an
// expected queue filled when a capture is driven and drained after the edge.
// -----------------------------------------------------------------------------
module tb_not_16;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic         en;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         out_valid;

    int checks;
    int errors;

    logic [W-1:0] exp_q[$];

    not_16 #(.WIDTH(W), .RST_VAL(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .en        (en),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive a value and check the combinational output after settling.
    task automatic drive_comb(input logic [W-1:0] v, input logic [W-1:0] e,
                              input string tag);
        in = v;
        #1;
        check(tag, out, e);
    endtask

    // Drive a capture at the falling edge, run one rising edge, compare
    // against the oldest expected entry.
    task automatic capture(input logic [W-1:0] v, input logic [W-1:0] e);
        logic [W-1:0] want;
        @(negedge clk);
        in = v;
        en = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        en = 1'b0;
        want = exp_q.pop_front();
        check("capture_q", out_q, want);
        check("capture_valid", {15'd0, out_valid}, 16'h0001);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en  = 1'b1;
        in  = 16'h1975;

        // Reset held with clock running and en=1: register stays cleared.
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", out_q, 16'h0000);
        check("rst_valid", {15'd0, out_valid}, 16'h0000);
        check("rst_comb", out, 16'hE68A);

        // Combinational vectors.
        drive_comb(16'h1975, 16'hE68A, "comb_1975");
        drive_comb(16'hF975, 16'h068A, "comb_f975");
        drive_comb(16'hFFFF, 16'h0000, "comb_ffff");
        drive_comb(16'h0000, 16'hFFFF, "comb_0000");
        drive_comb(16'hA5C3, 16'h5A3C, "comb_a5c3");
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] one;
            one = 16'h0001 << i;
            drive_comb(one, ~one, $sformatf("walk1_%0d", i));
        end

        // Release reset and capture 0x1975.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        capture(16'h1975, 16'hE68A);

        // Hold with en=0 for three edges while in changes.
        @(negedge clk);
        in = 16'hAAAA;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold_q", out_q, 16'hE68A);
            check("hold_valid", {15'd0, out_valid}, 16'h0001);
            check("hold_comb", out, 16'h5555);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_q", out_q, 16'h0000);
        check("async_rst_valid", {15'd0, out_valid}, 16'h0000);
        check("async_rst_comb", out, 16'h5555);

        // Release with en=0: nothing captured yet.
        @(negedge clk);
        rst = 1'b0;
        in  = 16'h1234;
        @(posedge clk);
        #1;
        check("post_rst_q", out_q, 16'h0000);
        check("post_rst_valid", {15'd0, out_valid}, 16'h0000);

        // First enabled edge after reset, then back-to-back captures.
        capture(16'h1234, 16'hEDCB);
        capture(16'hFFFF, 16'h0000);
        capture(16'h0000, 16'hFFFF);
        capture(16'h8001, 16'h7FFE);
        capture(16'h0F0F, 16'hF0F0);

        check("queue_empty", exp_q.size(), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
